axis_emitter: RTL
=================

# axis_emitter

Output stage of the blender datapath, the transmit-side counterpart of the per-layer shifters. It owns the frame scan: it drives `col_idx`/`row_idx` to the layer shifters and mixer, pulls one composed pixel per position over the need/valid/next pull interface, and emits the frame as an AXI4-Stream master. It generates `tuser` at start of frame and `tlast` at end of line. One registered output stage gives full throughput under continuous `tready`.

## Interface
- `C_PIXEL_WIDTH`, 8, pixel data width in bits
- `C_IMG_WBITS`, 12, width of column index and image width
- `C_IMG_HBITS`, 12, width of row index and image height

- `clk` in 1: single clock; all logic rising-edge.
- `resetn` in 1: **asynchronous, active-low** reset.
- `start` in 1: frame request; sampled only in IDLE.
- `img_width` in C_IMG_WBITS: pixels per line; latched on accepted `start`.
- `img_height` in C_IMG_HBITS: lines per frame; latched on accepted `start`.
- `col_idx` out C_IMG_WBITS: current scan column (registered).
- `row_idx` out C_IMG_HBITS: current scan row (registered).
- `s_pixel_valid` in 1: composed pixel for (`col_idx`,`row_idx`) is available.
- `s_pixel_data` in C_PIXEL_WIDTH: composed pixel.
- `s_pixel_next` out 1: combinational; pixel consumed this cycle.
- `m_axis_tvalid` out 1: output pixel valid.
- `m_axis_tdata` out C_PIXEL_WIDTH: output pixel.
- `m_axis_tuser` out 1: start of frame (first pixel only).
- `m_axis_tlast` out 1: last pixel of each line.
- `m_axis_tready` in 1: downstream ready.
- `busy` out 1: high in RUN and FLUSH.
- `frame_done` out 1: one-cycle pulse on transfer of the frame's final pixel.

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE: `start`=1 with `img_width`≠0 and `img_height`≠0 → latch sizes, `col_idx`=`row_idx`=0, go RUN. `start` with either size zero is ignored (stay IDLE, no `frame_done`).
- RUN: `s_pixel_next` = `s_pixel_valid` & (~`m_axis_tvalid` | `m_axis_tready`). Outside RUN, `s_pixel_next`=0.
- On `s_pixel_next`: load `m_axis_tdata`←`s_pixel_data`; `tuser`←(col==0 && row==0); `tlast`←(col==W-1); set `m_axis_tvalid`. Advance index: col+1, or col←0 and row+1 when col==W-1.
- When the consumed pixel is (W-1,H-1), go FLUSH; indices hold at (W-1,H-1).
- FLUSH: no consumption. When `m_axis_tvalid`&`m_axis_tready`, clear `tvalid`, pulse `frame_done`, go IDLE, indices return to 0.
- Output handshake without a new load clears `m_axis_tvalid`. `tdata`/`tuser`/`tlast` hold until the next load.
- Comparisons are at full C_IMG_WBITS/C_IMG_HBITS width. W=1 gives `tlast` on every pixel. W=H=1 gives a single pixel with `tuser`=`tlast`=1.
- `start` during RUN/FLUSH is ignored. Size input changes mid-frame have no effect.

## Timing
- Reset (async assert, sync deassert at flop level): state IDLE, `col_idx`=`row_idx`=0, `m_axis_tvalid`=`tuser`=`tlast`=0, `tdata`=0, `busy`=0, `frame_done`=0. Reset mid-frame discards the frame with no `frame_done`.
- `start` accepted at edge N → `busy`=1 and RUN from cycle N+1. The first `s_pixel_next` can occur in cycle N+1.
- Latency from `s_pixel_next` to `m_axis_tvalid`: 1 cycle.
- With `s_pixel_valid` and `tready` held high, the block transfers 1 pixel/cycle. A W×H frame occupies W·H+1 cycles from `start` to `frame_done`.
- Index changes are visible the cycle after consumption. Upstream sees the new position before it must present the next pixel.
- `tready` low with `tvalid` high: all outputs stable and `s_pixel_next`=0.

## Configuration
- `AXIS_EMITTER_FRAME_CNT_EN` defined: adds output `frame_cnt` [15:0]. It resets to 0, increments on each `frame_done`, and wraps 0xFFFF→0.
- Not defined: port and counter are absent. All other behaviour is identical.

## Test plan
- W=4,H=2, `s_pixel_valid`=`tready`=1, data = col+4·row → 8 beats with data 0..7, `tuser` on beat 0 only, `tlast` on beats 3 and 7, `frame_done` 9 cycles after `start`.
- Same frame with `tready` toggling 1,0 → no beat lost or duplicated, `tdata` stable while stalled, `s_pixel_next` low when stalled and full.
- W=1,H=1 → single beat with `tuser`=`tlast`=1. `start` with W=0,H=5 → stays IDLE, `busy`=0.
- `s_pixel_valid` gaps of 3 cycles every pixel at W=3,H=3 → indices advance only on consumption, 9 beats in order.
- `resetn` low at pixel 5 of a 4×4 frame → all outputs zero immediately. A new `start` then produces a clean frame with `tuser` on its first beat.
- With `AXIS_EMITTER_FRAME_CNT_EN`: three back-to-back 2×2 frames → `frame_cnt` reads 1,2,3. Preloading to 0xFFFF by 65535 frames (or force) then one more frame → 0.

Source files
------------

// File: rtl/axis_emitter.sv
// Frame scanner and AXI4-Stream master for the blender output stage.
// Define AXIS_EMITTER_FRAME_CNT_EN to add the frame_cnt output.
module axis_emitter #(
  parameter int C_PIXEL_WIDTH = 8,
  parameter int C_IMG_WBITS   = 12,
  parameter int C_IMG_HBITS   = 12
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start,
  input  logic [C_IMG_WBITS-1:0]   img_width,
  input  logic [C_IMG_HBITS-1:0]   img_height,
  output logic [C_IMG_WBITS-1:0]   col_idx,
  output logic [C_IMG_HBITS-1:0]   row_idx,
  input  logic                     s_pixel_valid,
  input  logic [C_PIXEL_WIDTH-1:0] s_pixel_data,
  output logic                     s_pixel_next,
  output logic                     m_axis_tvalid,
  output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                     m_axis_tuser,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic                     busy,
`ifdef AXIS_EMITTER_FRAME_CNT_EN
  output logic                     frame_done,
  output logic [15:0]              frame_cnt
`else
  output logic                     frame_done
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  localparam logic [C_IMG_WBITS-1:0] W_ONE = 1;
  localparam logic [C_IMG_HBITS-1:0] H_ONE = 1;

  state_t                 state;
  state_t                 state_nxt;
  logic [C_IMG_WBITS-1:0] width_q;
  logic [C_IMG_HBITS-1:0] height_q;
  logic                   last_col;
  logic                   last_row;
  logic                   accept;

  assign last_col = (col_idx == width_q - W_ONE);
  assign last_row = (row_idx == height_q - H_ONE);
  assign accept   = start && (|img_width) && (|img_height);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    s_pixel_next = 1'b0;
    frame_done   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = RUN;
      end
      RUN: begin
        s_pixel_next = s_pixel_valid &
                       (~m_axis_tvalid | m_axis_tready);
        if (s_pixel_next && last_col && last_row)
          state_nxt = FLUSH;
      end
      FLUSH: begin
        if (m_axis_tvalid && m_axis_tready) begin
          frame_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Scan position; holds on the final pixel until it drains.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      width_q  <= '0;
      height_q <= '0;
      col_idx  <= '0;
      row_idx  <= '0;
    end else if (state == IDLE) begin
      if (accept) begin
        width_q  <= img_width;
        height_q <= img_height;
        col_idx  <= '0;
        row_idx  <= '0;
      end
    end else if (s_pixel_next) begin
      if (!last_col) begin
        col_idx <= col_idx + W_ONE;
      end else if (!last_row) begin
        col_idx <= '0;
        row_idx <= row_idx + H_ONE;
      end
    end else if (frame_done) begin
      col_idx <= '0;
      row_idx <= '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (s_pixel_next) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s_pixel_data;
      m_axis_tuser  <= (col_idx == '0) && (row_idx == '0);
      m_axis_tlast  <= last_col;
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef AXIS_EMITTER_FRAME_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)         frame_cnt <= '0;
    else if (frame_done) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule
